// File: rtl/fr_adder_pkg.sv
// Shared types and constants for the mantissa adder finish stage (carry resolve + sum).
package fr_adder_pkg;

  localparam int FR_SUM_W         = 25;
  localparam int FR_PREFIX_LEVELS = 5;

  typedef struct packed {
    logic                valid;
    logic                sign;
    logic [FR_SUM_W-1:0] porig;
    logic [FR_SUM_W-1:0] g;
    logic [FR_SUM_W-1:0] p;
  } fr_stage_t;

  function automatic int fr_latency(input int lps);
    return (FR_PREFIX_LEVELS + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/fr_prefix_cell.sv
// Kogge-Stone (G,P) combine operator: (G,P) o (G',P') = (G | P&G', P&P').
module fr_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/fr_adder_finish.sv
// Pipelined Kogge-Stone carry resolve and sum for the mantissa adder, elastic valid/ready.
// Optional macro FR_ADDER_CIN_EN adds an in_cin port driving the carry-in slot (bit 0).
module fr_adder_finish
  import fr_adder_pkg::*;
#(
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FR_SUM_W-1:0] G0,
  input  logic [FR_SUM_W-1:0] P0,
  input  logic                in_sign,
`ifdef FR_ADDER_CIN_EN
  input  logic                in_cin,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FR_SUM_W-1:0] sum,
  output logic                out_sign
);

  localparam int LATENCY = fr_latency(LEVELS_PER_STAGE);

  if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > FR_PREFIX_LEVELS || LATENCY < 1) begin : g_bad_lps
    $error("fr_adder_finish: LEVELS_PER_STAGE must be in 1..5");
  end

  logic advance;
  logic out_valid_q, out_valid_d;
  logic out_sign_q, out_sign_d;
  logic [FR_SUM_W-1:0] sum_q, sum_d;

  // Whole pipe moves together; a held output freezes everything behind it.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  fr_stage_t stg_in;

  always_comb begin
    stg_in       = '0;
    stg_in.valid = in_valid;
    stg_in.sign  = in_sign;
    stg_in.porig = {P0[FR_SUM_W-1:1], 1'b0};
    stg_in.p     = {P0[FR_SUM_W-1:1], 1'b0};
`ifdef FR_ADDER_CIN_EN
    stg_in.g     = {G0[FR_SUM_W-1:1], in_cin};
`else
    stg_in.g     = {G0[FR_SUM_W-1:1], 1'b0};
`endif
  end

  for (genvar k = 1; k <= FR_PREFIX_LEVELS; k++) begin : lvl_g
    localparam int SPAN = 1 << (k - 1);
    fr_stage_t           src, lv, nxt;
    logic [FR_SUM_W-1:0] g_n, p_n;

    if (k == 1) begin : g_src_in
      assign src = stg_in;
    end else begin : g_src_prev
      assign src = lvl_g[k-1].nxt;
    end

    for (genvar i = 0; i < FR_SUM_W; i++) begin : bit_g
      if (i >= SPAN) begin : g_cell
        fr_prefix_cell u_cell (
          .g_hi(src.g[i]),
          .p_hi(src.p[i]),
          .g_lo(src.g[i-SPAN]),
          .p_lo(src.p[i-SPAN]),
          .g   (g_n[i]),
          .p   (p_n[i])
        );
      end else begin : g_pass
        assign g_n[i] = src.g[i];
        assign p_n[i] = src.p[i];
      end
    end

    assign lv = {src.valid, src.sign, src.porig, g_n, p_n};

    // Stage boundary every LEVELS_PER_STAGE levels; the last level feeds the output register.
    if (k < FR_PREFIX_LEVELS && (k % LEVELS_PER_STAGE) == 0) begin : g_reg
      fr_stage_t stage_q, stage_d;
      assign stage_d = advance ? lv : stage_q;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) stage_q <= '0;
        else         stage_q <= stage_d;
      end
      assign nxt = stage_q;
    end else begin : g_comb
      assign nxt = lv;
    end
  end

  fr_stage_t           fin;
  logic [FR_SUM_W-1:0] sum_c;
  logic                unused_bits;

  assign fin         = lvl_g[FR_PREFIX_LEVELS].nxt;
  // Carry into operand bit i-1 is the prefix generate of slot i-1.
  assign sum_c       = {fin.g[FR_SUM_W-1], fin.porig[FR_SUM_W-1:1] ^ fin.g[FR_SUM_W-2:0]};
  assign unused_bits = ^{fin.p, fin.porig[0], G0[0], P0[0]};

  always_comb begin
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    sum_d       = sum_q;
    if (advance) begin
      out_valid_d = fin.valid;
      out_sign_d  = fin.sign;
      sum_d       = sum_c;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      sum_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      sum_q       <= sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign sum       = sum_q;

endmodule
